// File: rtl/fxp_adder_rr_scheduler_if.sv
// Request/response bundle between N requesters and the shared-adder scheduler.
// master: requester side (drives operands and response accept).
// slave : scheduler side (drives accept, result valid and result data).
interface fxp_adder_rr_scheduler_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a;
  logic [N*W-1:0]     req_b;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [N*(W+1)-1:0] rsp_sum;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum
  );
endinterface

// File: rtl/fxp_adder_rr_scheduler.sv
// Purpose : round-robin share of one external pipelined signed adder among N requesters.
// Latency : request handshake at edge k -> rsp_valid after edge k+ADD_LAT; one issue per cycle.
// Backpr. : one op in flight per requester; result held until rsp_ready, requester blocked meanwhile.
// Ports   : clk/rst_n (async active-low); bus = per-requester req/rsp valid-ready channels;
//           add_a/add_b -> adder operands, add_sum <- adder result; idle = no requester busy;
//           issue_cnt = accepted operations (wraps).
module fxp_adder_rr_scheduler #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fxp_adder_rr_scheduler_if.slave bus,
  output logic [W-1:0]            add_a,
  output logic [W-1:0]            add_b,
  input  logic [W:0]              add_sum,
  output logic                    idle,
  output logic [CNT_W-1:0]        issue_cnt
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  // One slot of the tag pipe: which requester owns the sum emerging from the adder.
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [N-1:0]       busy;
  logic [N-1:0]       elig;
  logic [N-1:0]       grant;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     scan_idx;
  logic               any_grant;
  logic [IDW-1:0]     last;
  tag_t               tag_pipe [ADD_LAT];
  tag_t               tag_out;
  logic [N-1:0]       rsp_set;
  logic [N-1:0]       rsp_hs;
  logic [N-1:0]       rsp_vld_q;
  logic [N*(W+1)-1:0] rsp_sum_q;

  // (base + off) mod N, with off in 1..N so a single subtract suffices.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  // Busy is the registered copy, so a requester whose response is consumed this
  // cycle only becomes eligible again on the following cycle.
  assign elig = bus.req_valid & ~busy;

  // Scan starts just after the last winner; depends only on valid/busy, never on operands.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    scan_idx  = '0;
    any_grant = 1'b0;
    for (int off = 1; off <= N; off++) begin
      scan_idx = rr_idx(last, off);
      if (!any_grant && elig[scan_idx]) begin
        any_grant = 1'b1;
        grant_id  = scan_idx;
      end
    end
    if (any_grant) grant[grant_id] = 1'b1;
  end

  assign bus.req_ready = grant;

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        add_a = bus.req_a[i*W +: W];
        add_b = bus.req_b[i*W +: W];
      end
    end
  end

  // Tag pipe mirrors the adder depth; a bubble is shifted in on cycles with no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ADD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= {any_grant, grant_id};
      for (int s = 1; s < ADD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign tag_out = tag_pipe[ADD_LAT-1];

  always_comb begin
    rsp_set = '0;
    for (int i = 0; i < N; i++) begin
      rsp_set[i] = tag_out.vld && (tag_out.id == IDW'(i));
    end
  end

  assign rsp_hs = rsp_vld_q & bus.rsp_ready;

  // A set and a clear on the same requester cannot coincide: a requester holding
  // a response is busy and so has nothing in the tag pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      last      <= IDW'(N-1);
      issue_cnt <= '0;
      rsp_vld_q <= '0;
      rsp_sum_q <= '0;
    end else begin
      busy      <= (busy | grant) & ~rsp_hs;
      rsp_vld_q <= (rsp_vld_q & ~rsp_hs) | rsp_set;
      if (any_grant) begin
        last      <= grant_id;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_set[i]) rsp_sum_q[i*(W+1) +: W+1] <= add_sum;
      end
    end
  end

  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign idle          = ~|busy;

endmodule

// File: tb/tb_fxp_adder_rr_scheduler.sv
// Bench for fxp_adder_rr_scheduler: directed and randomized scenarios checked
// cycle by cycle against a transaction-level reference (round-robin rule,
// per-requester busy flags and a delay queue of expected sums).
`timescale 1ns/1ps
module tb_fxp_adder_rr_scheduler;
  localparam int N = 4, W = 8, ADD_LAT = 1, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     add_a, add_b;
  logic [W:0]       add_sum;
  logic             idle;
  logic [CNT_W-1:0] issue_cnt;

  fxp_adder_rr_scheduler_if #(.N(N), .W(W)) bus ();

  fxp_adder_rr_scheduler #(.N(N), .W(W), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .idle(idle), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // External adder: operands sampled on each edge, sum out after ADD_LAT-1 more edges.
  logic [W:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= {add_a[W-1], add_a} + {add_b[W-1], add_b};
    for (int s = 1; s < ADD_LAT; s++) add_pipe[s] <= add_pipe[s-1];
  end
  assign add_sum = add_pipe[ADD_LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int         id;
    logic [W:0] sum;
    int         due;
  } flight_t;

  flight_t            flight[$];
  logic [N-1:0]       m_busy, m_rsp_vld;
  logic [N*(W+1)-1:0] m_rsp_sum;
  logic [CNT_W-1:0]   m_cnt;
  int                 m_last, edge_no;
  logic [N-1:0]       e_grant;
  logic [W-1:0]       e_add_a, e_add_b;
  int                 e_id;
  bit                 drop_on_accept;
  int                 nvec = 0, nerr = 0;

  function automatic logic [W:0] sum_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb;
    return s[W:0];
  endfunction

  task automatic model_reset();
    m_busy = '0; m_rsp_vld = '0; m_rsp_sum = '0; m_cnt = '0;
    m_last = N - 1;
    flight.delete();
  endtask

  // Expected winner: first requester after the previous winner that wants to issue and is not busy.
  task automatic predict();
    #1;
    e_grant = '0; e_add_a = '0; e_add_b = '0; e_id = -1;
    for (int off = 1; off <= N; off++) begin
      int j = (m_last + off) % N;
      if (e_id < 0 && bus.req_valid[j] && !m_busy[j]) e_id = j;
    end
    if (e_id >= 0) begin
      e_grant[e_id] = 1'b1;
      e_add_a = bus.req_a[e_id*W +: W];
      e_add_b = bus.req_b[e_id*W +: W];
    end
  endtask

  task automatic clock_model();
    flight_t f;
    @(posedge clk);
    edge_no++;
    for (int i = 0; i < N; i++) begin
      if (m_rsp_vld[i] && bus.rsp_ready[i]) begin
        m_rsp_vld[i] = 1'b0;
        m_busy[i]    = 1'b0;
      end
    end
    while (flight.size() > 0 && flight[0].due == edge_no) begin
      f = flight.pop_front();
      m_rsp_vld[f.id] = 1'b1;
      m_rsp_sum[f.id*(W+1) +: W+1] = f.sum;
    end
    if (e_id >= 0) begin
      m_busy[e_id] = 1'b1;
      m_last = e_id;
      m_cnt++;
      f.id = e_id; f.sum = sum_ref(e_add_a, e_add_b); f.due = edge_no + ADD_LAT;
      flight.push_back(f);
    end
    @(negedge clk);
    if (drop_on_accept && e_id >= 0) bus.req_valid[e_id] = 1'b0;
  endtask

  task automatic do_reset();
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    drop_on_accept = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = W'($urandom);
      bus.req_b[i*W +: W] = W'($urandom);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    nvec++;
    if ({bus.rsp_valid, bus.rsp_sum, idle, issue_cnt, bus.req_ready} !== {{N{1'b0}}, {N*(W+1){1'b0}}, 1'b1, {CNT_W{1'b0}}, {N{1'b0}}}) begin
      nerr++;
      $display("FAIL reset_state got vld=%b sum=%h idle=%b cnt=%0d rdy=%b need 0/0/1/0/0",
               bus.rsp_valid, bus.rsp_sum, idle, issue_cnt, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '1;
    #1;
    nvec++;
    if (bus.req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL reset_first_priority got=%b need=0001", bus.req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    drop_on_accept = 1'b1;
    bus.rsp_ready = '1;
    bus.req_a[W-1:0] = 8'd127;
    bus.req_b[W-1:0] = 8'hFF;
    bus.req_valid = 4'b0001;
    for (int c = 0; c < ADD_LAT + 4; c++) begin
      predict();
      if (c == 0) begin
        nvec++;
        if (bus.req_ready !== 4'b0001) begin nerr++; $display("FAIL single_grant got=%b need=0001", bus.req_ready); end
      end
      if (c == ADD_LAT + 1) begin
        nvec++;
        if ({bus.rsp_valid[0], bus.rsp_sum[W:0]} !== {1'b1, 9'd126}) begin
          nerr++; $display("FAIL single_result got vld=%b sum=%0d need vld=1 sum=126", bus.rsp_valid[0], bus.rsp_sum[W:0]);
        end
      end
      nvec++;
      if ({bus.req_ready, add_a, add_b} !== {e_grant, e_add_a, e_add_b}) begin
        nerr++; $display("FAIL single_issue c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b}, {e_grant, e_add_a, e_add_b});
      end
      nvec++;
      if ({bus.rsp_valid, bus.rsp_sum, idle, issue_cnt} !== {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt}) begin
        nerr++; $display("FAIL single_rsp c=%0d got=%h need=%h", c, {bus.rsp_valid, bus.rsp_sum, idle, issue_cnt}, {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt});
      end
      clock_model();
    end
    nvec++;
    if ({issue_cnt, idle} !== {CNT_W'(1), 1'b1}) begin
      nerr++; $display("FAIL single_end got cnt=%0d idle=%b need cnt=1 idle=1", issue_cnt, idle);
    end
  endtask

  task automatic test_all_four();
    int order[$];
    logic [N*(W+1)-1:0] exp_s;
    do_reset();
    drop_on_accept = 1'b1;
    bus.rsp_ready = '1;
    bus.req_a = {8'h80, 8'hF6, 8'd23, 8'd15};
    bus.req_b = {8'd1,  8'hFB, 8'd17, 8'd10};
    bus.req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      predict();
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) order.push_back(i);
      nvec++;
      if ({bus.req_ready, add_a, add_b} !== {e_grant, e_add_a, e_add_b}) begin
        nerr++; $display("FAIL four_issue c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b}, {e_grant, e_add_a, e_add_b});
      end
      nvec++;
      if ({bus.rsp_valid, bus.rsp_sum, idle, issue_cnt} !== {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt}) begin
        nerr++; $display("FAIL four_rsp c=%0d got=%h need=%h", c, {bus.rsp_valid, bus.rsp_sum, idle, issue_cnt}, {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt});
      end
      clock_model();
    end
    nvec++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
      nerr++; $display("FAIL four_order got %0d grants %p need 0,1,2,3", order.size(), order);
    end
    exp_s = {9'h181, 9'h1F1, 9'd40, 9'd25};
    nvec++;
    if (bus.rsp_sum !== exp_s) begin
      nerr++; $display("FAIL four_sums got=%h need=%h", bus.rsp_sum, exp_s);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    drop_on_accept = 1'b1;
    bus.rsp_ready = '1;
    bus.req_a[2*W +: W] = 8'd127; bus.req_b[2*W +: W] = 8'd127;
    bus.req_a[3*W +: W] = 8'h80;  bus.req_b[3*W +: W] = 8'h80;
    bus.req_valid = 4'b1100;
    for (int c = 0; c < 6; c++) begin
      predict();
      nvec++;
      if ({bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum} !== {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum}) begin
        nerr++; $display("FAIL ext_cycle c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum}, {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum});
      end
      clock_model();
    end
    nvec++;
    if ({bus.rsp_sum[3*(W+1) +: W+1], bus.rsp_sum[2*(W+1) +: W+1]} !== {9'h100, 9'h0FE}) begin
      nerr++; $display("FAIL ext_sums got r3=%h r2=%h need r3=100 r2=0fe", bus.rsp_sum[3*(W+1) +: W+1], bus.rsp_sum[2*(W+1) +: W+1]);
    end
  endtask

  task automatic test_backpressure();
    int held = 0;
    int others = 0;
    do_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 4'b1101;
    for (int c = 0; c < 30; c++) begin
      rand_ops();
      bus.rsp_ready[1] = (held >= 5) ? 1'b1 : 1'b0;
      predict();
      if (m_rsp_vld[1] && held < 5) begin
        held++;
        for (int i = 0; i < N; i++) if (i != 1 && bus.req_ready[i]) others++;
        nvec++;
        if (bus.req_ready[1] !== 1'b0) begin nerr++; $display("FAIL bp_blocked c=%0d got req_ready[1]=%b need 0", c, bus.req_ready[1]); end
      end
      nvec++;
      if ({bus.req_ready, add_a, add_b} !== {e_grant, e_add_a, e_add_b}) begin
        nerr++; $display("FAIL bp_issue c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b}, {e_grant, e_add_a, e_add_b});
      end
      nvec++;
      if ({bus.rsp_valid, bus.rsp_sum, idle, issue_cnt} !== {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt}) begin
        nerr++; $display("FAIL bp_rsp c=%0d got=%h need=%h", c, {bus.rsp_valid, bus.rsp_sum, idle, issue_cnt}, {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt});
      end
      clock_model();
    end
    nvec++;
    if (held != 5 || others == 0) begin
      nerr++; $display("FAIL bp_progress got held=%0d other_grants=%0d need held=5 other_grants>0", held, others);
    end
  endtask

  task automatic test_fairness();
    int g[N];
    int mn, mx, tot;
    do_reset();
    for (int i = 0; i < N; i++) g[i] = 0;
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    for (int c = 0; c < 40; c++) begin
      rand_ops();
      predict();
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) g[i]++;
      nvec++;
      if ($countones(bus.req_ready) > 1) begin nerr++; $display("FAIL fair_onehot c=%0d got=%b need at most one bit", c, bus.req_ready); end
      nvec++;
      if ({bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum} !== {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum}) begin
        nerr++; $display("FAIL fair_cycle c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum}, {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum});
      end
      clock_model();
    end
    mn = g[0]; mx = g[0]; tot = 0;
    for (int i = 0; i < N; i++) begin
      if (g[i] < mn) mn = g[i];
      if (g[i] > mx) mx = g[i];
      tot += g[i];
    end
    nvec++;
    if (mx - mn > 1 || tot != 40) begin
      nerr++; $display("FAIL fair_share got min=%0d max=%0d total=%0d need spread<=1 total=40", mn, mx, tot);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++) bus.rsp_ready[i] = ($urandom_range(0, 9) < 7);
      predict();
      nvec++;
      if ({bus.req_ready, add_a, add_b} !== {e_grant, e_add_a, e_add_b}) begin
        nerr++; $display("FAIL rand_issue c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b}, {e_grant, e_add_a, e_add_b});
      end
      nvec++;
      if ({bus.rsp_valid, bus.rsp_sum, idle, issue_cnt} !== {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt}) begin
        nerr++; $display("FAIL rand_rsp c=%0d got=%h need=%h", c, {bus.rsp_valid, bus.rsp_sum, idle, issue_cnt}, {m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt});
      end
      clock_model();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drop_on_accept = 1'b1;
    rand_ops();
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      predict();
      nvec++;
      if ({bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum} !== {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum}) begin
        nerr++; $display("FAIL mid_pre c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum}, {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum});
      end
      clock_model();
    end
    #1;
    nvec++;
    if ({issue_cnt, idle} !== {CNT_W'(2), 1'b0}) begin
      nerr++; $display("FAIL mid_inflight got cnt=%0d idle=%b need cnt=2 idle=0", issue_cnt, idle);
    end
    #1;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({bus.rsp_valid, idle, issue_cnt} !== {{N{1'b0}}, 1'b1, {CNT_W{1'b0}}}) begin
      nerr++; $display("FAIL mid_async got vld=%b idle=%b cnt=%0d need 0/1/0", bus.rsp_valid, idle, issue_cnt);
    end
    do_reset();
    bus.rsp_ready = '1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 4) begin rand_ops(); bus.req_valid = N'($urandom); end
      predict();
      if (c < 4) begin
        nvec++;
        if (bus.rsp_valid !== '0) begin nerr++; $display("FAIL mid_stale c=%0d got rsp_valid=%b need 0", c, bus.rsp_valid); end
      end
      nvec++;
      if ({bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum, idle, issue_cnt} !== {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt}) begin
        nerr++; $display("FAIL mid_post c=%0d got=%h need=%h", c, {bus.req_ready, add_a, add_b, bus.rsp_valid, bus.rsp_sum, idle, issue_cnt}, {e_grant, e_add_a, e_add_b, m_rsp_vld, m_rsp_sum, ~|m_busy, m_cnt});
      end
      clock_model();
    end
  endtask

  initial begin
    edge_no = 0;
    drop_on_accept = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    test_reset();
    test_single();
    test_all_four();
    test_extremes();
    test_backpressure();
    test_fairness();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
